// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer, y_j = act(b_j + sum_i w_ji*x_i), one shared multiplier.
// Latency: out_valid rises N_OUT*(N_IN+1)+1 cycles after the input accept edge (67 at defaults).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; no overlap of jobs.
//
// Ports:
//   clk_i, rst_n_i                   clock (rising edge), asynchronous active-low reset
//   x_i / in_valid_i / in_ready_o    input vector, element i at [BITSIZE*i +: BITSIZE]
//   y_o / out_valid_o / out_ready_i  output vector, neuron j at [BITSIZE*j +: BITSIZE]
//   act_mode_i                       0 = linear, 1 = ReLU (sampled at accept)
//   wr_en_i/wr_bias_i/wr_addr_i/wr_data_i  runtime weight/bias load; wr_err_o pulses on a rejected write
//   sat_flag_o                       any neuron of the current result saturated
//   busy_o                           computation in progress
// All words are sign-magnitude with FRAC_BITS fractional bits.
module dense_layer_seq #(
    parameter int BITSIZE   = 16,
    parameter int N_IN      = 10,
    parameter int N_OUT     = 6,
    parameter int FRAC_BITS = 8,
    parameter int ACC_GUARD = 8,
    parameter int ADDR_W    = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [BITSIZE*N_IN-1:0]    x_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [BITSIZE*N_OUT-1:0]   y_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    input  logic                       act_mode_i,
    input  logic                       wr_en_i,
    input  logic                       wr_bias_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [BITSIZE-1:0]         wr_data_i,
    output logic                       wr_err_o,
    output logic                       sat_flag_o,
    output logic                       busy_o
);

    localparam int NW = N_IN * N_OUT;
    localparam int AW = BITSIZE + ACC_GUARD;   // accumulator width
    localparam int MW = BITSIZE - 1;           // magnitude width
    localparam int PW = 2 * MW;                // full product magnitude width
    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WW = (NW    > 1) ? $clog2(NW)    : 1;
    localparam logic [AW-1:0] MAX_MAG = AW'((2 ** MW) - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;

    state_t state_q, state_d;

    logic [BITSIZE-1:0]     w_q [NW];
    logic [BITSIZE-1:0]     b_q [N_OUT];
    logic [BITSIZE-1:0]     x_q [N_IN];
    logic [BITSIZE-1:0]     y_q [N_OUT];
    logic [IW-1:0]          i_q;
    logic [JW-1:0]          j_q;
    logic [WW-1:0]          wi_q;      // flat weight index j*N_IN+i, advances with every product
    logic signed [AW-1:0]   acc_q;
    logic                   act_q;
    logic                   sat_q;
    logic                   out_valid_q;
    logic                   wr_err_q;

    logic accept;
    logic wr_ok;
    logic i_last;
    logic j_last;

    assign in_ready_o  = (state_q == S_IDLE) && rst_n_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = out_valid_q;
    assign wr_err_o    = wr_err_q;
    assign sat_flag_o  = sat_q;
    assign busy_o      = (state_q == S_MAC) || (state_q == S_BIAS);
    assign i_last      = (i_q == IW'(N_IN - 1));
    assign j_last      = (j_q == JW'(N_OUT - 1));

    // Parameters may only change while no computation is reading them.
    assign wr_ok = wr_en_i && ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                   (wr_bias_i ? (int'(wr_addr_i) < N_OUT) : (int'(wr_addr_i) < NW));

    // ---------------- datapath arithmetic ----------------
    logic [BITSIZE-1:0]   w_cur, x_cur, b_cur;
    logic [PW-1:0]        pmag, pshift;
    logic [AW-1:0]        pext, bmag;
    logic signed [AW-1:0] prod_acc, bias_acc, sum, sum_act;
    logic [AW-1:0]        sum_mag;
    logic                 sum_neg, sat_n;
    logic [BITSIZE-1:0]   y_new;

    assign w_cur = w_q[wi_q];
    assign x_cur = x_q[i_q];
    assign b_cur = b_q[j_q];

    always_comb begin
        pmag     = PW'(w_cur[MW-1:0]) * PW'(x_cur[MW-1:0]);
        pshift   = pmag >> FRAC_BITS;                 // truncation toward zero on the magnitude
        pext     = AW'(pshift);
        prod_acc = (w_cur[MW] ^ x_cur[MW]) ? -$signed(pext) : $signed(pext);

        bmag     = AW'(b_cur[MW-1:0]);
        bias_acc = b_cur[MW] ? -$signed(bmag) : $signed(bmag);
        sum      = acc_q + bias_acc;
        sum_act  = (act_q && sum[AW-1]) ? '0 : sum;

        sum_neg  = sum_act[AW-1];
        sum_mag  = sum_neg ? AW'(-sum_act) : AW'(sum_act);
        sat_n    = (sum_mag > MAX_MAG);

        if (sat_n) begin
            y_new = {sum_neg, {MW{1'b1}}};
        end else if (sum_mag == '0) begin
            y_new = '0;                               // never emit -0
        end else begin
            y_new = {sum_neg, sum_mag[MW-1:0]};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_MAC;
            S_MAC:   if (i_last) state_d = S_BIAS;
            S_BIAS:  state_d = j_last ? S_DONE : S_MAC;
            S_DONE:  if (out_valid_q && out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- compute registers ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < N_IN; k++)  x_q[k] <= '0;
            for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
            i_q         <= '0;
            j_q         <= '0;
            wi_q        <= '0;
            acc_q       <= '0;
            act_q       <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // out_valid registers one cycle after DONE is entered and drops on the handshake edge.
            out_valid_q <= (state_q == S_DONE) && (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < N_IN; k++) x_q[k] <= x_i[BITSIZE*k +: BITSIZE];
                        act_q <= act_mode_i;
                        i_q   <= '0;
                        j_q   <= '0;
                        wi_q  <= '0;
                        acc_q <= '0;
                        sat_q <= 1'b0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + prod_acc;
                    i_q   <= i_last ? '0 : i_q + 1'b1;
                    if (wi_q != WW'(NW - 1)) wi_q <= wi_q + 1'b1;
                end
                S_BIAS: begin
                    y_q[j_q] <= y_new;
                    sat_q    <= sat_q | sat_n;
                    acc_q    <= '0;
                    if (!j_last) j_q <= j_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- parameter memory ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NW; k++)    w_q[k] <= '0;
            for (int k = 0; k < N_OUT; k++) b_q[k] <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en_i && !wr_ok;
            if (wr_ok) begin
                if (wr_bias_i) begin
                    for (int k = 0; k < N_OUT; k++)
                        if (wr_addr_i == ADDR_W'(k)) b_q[k] <= wr_data_i;
                end else begin
                    for (int k = 0; k < NW; k++)
                        if (wr_addr_i == ADDR_W'(k)) w_q[k] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        y_o = '0;
        for (int k = 0; k < N_OUT; k++) y_o[BITSIZE*k +: BITSIZE] = y_q[k];
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq at default parameters (N_IN=10, N_OUT=6, Q8 words).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed in sign-magnitude Q8 (1.0 = 0x0100).
module tb_dense_layer_seq;

    localparam int B  = 16;
    localparam int NI = 10;
    localparam int NO = 6;
    localparam int LAT = NO * (NI + 1) + 1;

    logic              clk;
    logic              rst_n;
    logic [B*NI-1:0]   x;
    logic              in_valid;
    logic              in_ready;
    logic [B*NO-1:0]   y;
    logic              out_valid;
    logic              out_ready;
    logic              act_mode;
    logic              wr_en;
    logic              wr_bias;
    logic [6:0]        wr_addr;
    logic [B-1:0]      wr_data;
    logic              wr_err;
    logic              sat_flag;
    logic              busy;

    int tests_run;
    int tests_failed;

    dense_layer_seq dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .x_i         (x),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .y_o         (y),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .act_mode_i  (act_mode),
        .wr_en_i     (wr_en),
        .wr_bias_i   (wr_bias),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_err_o    (wr_err),
        .sat_flag_o  (sat_flag),
        .busy_o      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic b, input int a, input logic [B-1:0] d);
        wr_en = 1'b1; wr_bias = b; wr_addr = 7'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic set_weights(input logic [B-1:0] d);
        for (int k = 0; k < NI * NO; k++) wr(1'b0, k, d);
    endtask

    task automatic set_x(input logic [B-1:0] d);
        for (int k = 0; k < NI; k++) x[B*k +: B] = d;
    endtask

    // Waits for in_ready, accepts one vector; act_mode is flipped after accept
    // so a result depends only on the value sampled at the accept edge.
    task automatic start(input logic act);
        int k;
        act_mode = act;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
        if (!in_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL start_timeout in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        act_mode = ~act;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        tests_run++; if (y !== '0) begin tests_failed++; $display("FAIL reset_y got=%h want=0", y); end
        tests_run++; if ({busy, sat_flag, wr_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got=%b want=000", {busy, sat_flag, wr_err}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        set_weights(16'h0100);
        set_x(16'h0100);
        start(1'b0);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got=%b want=1", busy); end
        wait_done(lat);
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL basic_y%0d got=%h want=0a00", j, y[B*j +: B]); end
        end
        tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL basic_sat got=%b want=0", sat_flag); end
        handshake();
    endtask

    task automatic test_negative_x();
        int lat;
        set_x(16'h8080);   // -0.5 everywhere: sum = -5.0
        start(1'b0);
        wait_done(lat);
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h8500) begin tests_failed++; $display("FAIL neg_lin_y%0d got=%h want=8500", j, y[B*j +: B]); end
        end
        handshake();
        start(1'b1);
        wait_done(lat);
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h0000) begin tests_failed++; $display("FAIL neg_relu_y%0d got=%h want=0000", j, y[B*j +: B]); end
        end
        handshake();
    endtask

    task automatic test_bias_relu();
        int lat;
        wr(1'b1, 0, 16'h8B00);   // bias_0 = -11.0
        set_x(16'h0100);
        start(1'b0);
        wait_done(lat);
        tests_run++; if (y[0 +: B] !== 16'h8100) begin tests_failed++; $display("FAIL bias_lin_y0 got=%h want=8100", y[0 +: B]); end
        for (int j = 1; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL bias_lin_y%0d got=%h want=0a00", j, y[B*j +: B]); end
        end
        handshake();
        start(1'b1);
        wait_done(lat);
        tests_run++; if (y[0 +: B] !== 16'h0000) begin tests_failed++; $display("FAIL bias_relu_y0 got=%h want=0000", y[0 +: B]); end
        tests_run++; if (y[B +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL bias_relu_y1 got=%h want=0a00", y[B +: B]); end
        handshake();
        wr(1'b1, 0, 16'h0000);
    endtask

    task automatic test_truncation();
        int lat;
        set_weights(16'h0080);   // 0.5
        set_x(16'h8001);         // tiny negative: each product truncates to -0
        start(1'b0);
        wait_done(lat);
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h0000) begin tests_failed++; $display("FAIL negzero_y%0d got=%h want=0000", j, y[B*j +: B]); end
        end
        handshake();
        set_x(16'h0003);         // 0x80*3 = 0x180 -> 1 LSB per product, 10 in total
        start(1'b0);
        wait_done(lat);
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h000A) begin tests_failed++; $display("FAIL trunc_y%0d got=%h want=000a", j, y[B*j +: B]); end
        end
        handshake();
    endtask

    task automatic test_saturation();
        int lat;
        set_weights(16'h7FFF);
        set_x(16'h7FFF);
        start(1'b0);
        wait_done(lat);
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h7FFF) begin tests_failed++; $display("FAIL satpos_y%0d got=%h want=7fff", j, y[B*j +: B]); end
        end
        tests_run++; if (sat_flag !== 1'b1) begin tests_failed++; $display("FAIL satpos_flag got=%b want=1", sat_flag); end
        handshake();
        set_weights(16'hFFFF);
        start(1'b0);
        wait_done(lat);
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'hFFFF) begin tests_failed++; $display("FAIL satneg_y%0d got=%h want=ffff", j, y[B*j +: B]); end
        end
        tests_run++; if (sat_flag !== 1'b1) begin tests_failed++; $display("FAIL satneg_flag got=%b want=1", sat_flag); end
        handshake();
        set_weights(16'h0100);
        set_x(16'h0100);
        start(1'b0);
        tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL sat_clear_on_accept got=%b want=0", sat_flag); end
        wait_done(lat);
        tests_run++; if (y[B*5 +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL sat_recover_y5 got=%h want=0a00", y[B*5 +: B]); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        start(1'b0);
        wait_done(lat);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || y[0 +: B] !== 16'h0A00) begin
                tests_failed++;
                $display("FAIL bp_hold ov=%b rdy=%b busy=%b y0=%h want 1 0 0 0a00", out_valid, in_ready, busy, y[0 +: B]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_write_busy();
        int lat;
        start(1'b0);
        repeat (19) @(posedge clk);
        #1;
        wr(1'b0, 0, 16'h0200);   // lands on accept+20, mid-computation
        tests_run++; if (wr_err !== 1'b1) begin tests_failed++; $display("FAIL busy_wr_err got=%b want=1", wr_err); end
        @(posedge clk); #1;
        tests_run++; if (wr_err !== 1'b0) begin tests_failed++; $display("FAIL busy_wr_err_pulse got=%b want=0", wr_err); end
        wait_done(lat);
        tests_run++; if (y[0 +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL busy_wr_y0 got=%h want=0a00", y[0 +: B]); end
        handshake();
        start(1'b0);
        wait_done(lat);
        tests_run++; if (y[0 +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL busy_wr_rerun_y0 got=%h want=0a00", y[0 +: B]); end
        handshake();
        wr(1'b0, 60, 16'h0200);
        tests_run++; if (wr_err !== 1'b1) begin tests_failed++; $display("FAIL range_w60 got=%b want=1", wr_err); end
        wr(1'b1, 6, 16'h0200);
        tests_run++; if (wr_err !== 1'b1) begin tests_failed++; $display("FAIL range_b6 got=%b want=1", wr_err); end
        wr(1'b0, 59, 16'h0100);
        tests_run++; if (wr_err !== 1'b0) begin tests_failed++; $display("FAIL range_w59 got=%b want=0", wr_err); end
    endtask

    task automatic test_write_accept();
        int lat;
        set_x(16'h0100);
        act_mode = 1'b0;
        in_valid = 1'b1;
        wr_en = 1'b1; wr_bias = 1'b0; wr_addr = 7'd0; wr_data = 16'h0200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wr_en    = 1'b0;
        tests_run++; if (wr_err !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL wa_edge wr_err=%b busy=%b want 0 1", wr_err, busy); end
        wait_done(lat);
        tests_run++; if (y[0 +: B] !== 16'h0B00) begin tests_failed++; $display("FAIL wa_y0 got=%h want=0b00", y[0 +: B]); end
        tests_run++; if (y[B +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL wa_y1 got=%h want=0a00", y[B +: B]); end
        handshake();
        wr(1'b0, 0, 16'h0100);
    endtask

    task automatic test_reset_abort();
        int lat;
        start(1'b0);
        repeat (29) @(posedge clk);
        #1;
        tests_run++; if (y[0 +: B] !== 16'h0A00) begin tests_failed++; $display("FAIL abort_pre_y0 got=%h want=0a00", y[0 +: B]); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || y !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_clear ov=%b busy=%b y=%h want 0 0 0", out_valid, busy, y);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_x(16'h0100);
        start(1'b0);
        wait_done(lat);
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL abort_rerun_latency got=%0d want=%0d", lat, LAT); end
        for (int j = 0; j < NO; j++) begin
            tests_run++;
            if (y[B*j +: B] !== 16'h0000) begin tests_failed++; $display("FAIL abort_rerun_y%0d got=%h want=0000", j, y[B*j +: B]); end
        end
        handshake();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        x         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        act_mode  = 1'b0;
        wr_en     = 1'b0;
        wr_bias   = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        test_reset();
        test_basic();
        test_negative_x();
        test_bias_relu();
        test_truncation();
        test_saturation();
        test_backpressure();
        test_write_busy();
        test_write_accept();
        test_reset_abort();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
Time-multiplexed, parametrised fully-connected layer for the arrhythmia encoder chain: y_j = act(b_j + sum_i w_ji*x_i) on sign-magnitude fixed-point words. It generalises the constant-weight enc layers: N_IN/N_OUT/FRAC_BITS are parameters, weights and biases are runtime-loadable, activation is selectable, and valid/ready handshakes are on both sides. One multiplier is shared across all products; it sits between input capture and the next encoder stage or lambda layer.

Parameters:
BITSIZE, 16, word width; bit BITSIZE-1 = sign, rest = magnitude
N_IN, 10, input vector length
N_OUT, 6, output vector length (neurons)
FRAC_BITS, 8, fractional bits of every word (1.0 = 0x0100 at defaults)
ACC_GUARD, 8, extra integer bits in accumulator
ADDR_W, 7, weight address width, must satisfy 2^ADDR_W >= N_IN*N_OUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
x  in  BITSIZE*N_IN  input vector, element i at [BITSIZE*i +: BITSIZE]
in_valid  in  1  x valid
in_ready  out  1  block can accept x
y  out  BITSIZE*N_OUT  output vector, neuron j at [BITSIZE*j +: BITSIZE]
out_valid  out  1  y valid
out_ready  in  1  downstream accepts y
act_mode  in  1  0 = linear, 1 = ReLU; sampled at input accept
wr_en  in  1  parameter write strobe
wr_bias  in  1  1 = bias write (addr = j), 0 = weight write (addr = j*N_IN+i)
wr_addr  in  ADDR_W  parameter address
wr_data  in  BITSIZE  parameter value, sign-magnitude
wr_err  out  1  one-cycle pulse: write rejected (busy or addr out of range)
sat_flag  out  1  sticky for current result: any neuron saturated
busy  out  1  high in MAC/BIAS states

Behaviour:
- Reset (reset=0, async): state IDLE; in_ready=0 while asserted, 1 the first cycle after release; out_valid=0, y=0, wr_err=0, sat_flag=0, busy=0; all weights, biases, latched x and counters cleared to 0.
- FSM: IDLE -> MAC on in_valid&&in_ready (latch x, act_mode; i=0, j=0, acc=0). MAC: one product per cycle; after i=N_IN-1 -> BIAS. BIAS (1 cycle): acc+b_j, activation, saturate, store y_j; if j<N_OUT-1 then j++, i=0, acc=0 -> MAC, else -> DONE. DONE: out_valid=1; on out_ready -> IDLE.
- in_ready=1 only in IDLE. Latency: accept at edge T; out_valid rises at edge T+N_OUT*(N_IN+1)+1 (67 at defaults).
- Arithmetic: product magnitude = |w|*|x|, shifted right FRAC_BITS (truncation toward zero), sign = XOR of signs; converted to two's complement and accumulated in BITSIZE+ACC_GUARD bits. Bias is added unshifted.
- Activation: ReLU maps negative sums to 0. Saturation: |sum| > 2^(BITSIZE-1)-1 clamps magnitude to all-ones with the sign kept, and sets sat_flag. -0 is normalised to +0 (0x0000). sat_flag clears on the next accept.
- y and sat_flag hold stable from DONE until the next result is stored; in DONE with out_ready=0, y holds indefinitely.
- Writes: accepted only in IDLE/DONE with addr in range (weights < N_IN*N_OUT, biases < N_OUT); otherwise ignored and wr_err pulses the next cycle. A write and an accept on the same IDLE edge: the write commits and the computation uses the new value.
- No pipeline overlap: a new x is never accepted before out_ready completes the handshake.
- Reset mid-operation aborts immediately; the result is discarded and parameters are cleared.

Test Plan:
- All weights 0x0100, biases 0, all x 0x0100, act_mode=0 -> every y_j = 0x0A00; out_valid at accept+67; sat_flag=0.
- As above, bias_0 = 0x8B00 (-11.0): act_mode=0 -> y_0 = 0x8100, y_1..5 = 0x0A00; act_mode=1 -> y_0 = 0x0000.
- Weights 0x7FFF, x 0x7FFF, biases 0 -> all y_j = 0x7FFF, sat_flag=1; then weights 0xFFFF -> all y_j = 0xFFFF, sat_flag=1.
- out_ready held low 5 cycles after out_valid -> y, out_valid stable, in_ready=0, in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
- wr_en during busy at cycle 20 (addr 0, data 0x0200) -> wr_err pulse, result unchanged (0x0A00); weight write addr 60 in IDLE -> wr_err pulse.
- reset low at cycle 30 of a computation -> out_valid=0, y=0 immediately; after release, rerun with x=0x0100 and no writes -> y all 0x0000.
